// File: rtl/clock_divider_controller_if.sv
// -----------------------------------------------------------------------------
// clock_divider_controller_if
// Reconfiguration handshake between the processor control logic (master) and
// the clock divider (slave). A transfer happens on a clock edge where
// cfg_valid and cfg_ready are both high.
//
// Signals:
//   cfg_valid  master -> slave  new divide value offered on cfg_div
//   cfg_div    master -> slave  requested divide value (half period = cfg_div+1)
//   cfg_ready  slave -> master  divider can accept a new value
// -----------------------------------------------------------------------------
interface clock_divider_controller_if #(
    parameter int WIDTH = 8
);
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready
    );
endinterface

// File: rtl/clock_divider_controller.sv
// -----------------------------------------------------------------------------
// clock_divider_controller
// Runtime-controlled counter clock divider. The half period is (div+1) cycles
// of i_clk. New divide values are taken over the handshake port and applied
// only at a half-period boundary (or while idle), so o_divided_clk never
// produces a runt pulse. o_tick pulses for one cycle after every toggle.
// Stopping while the output is high drains the current high phase first.
//
// FSM states:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | stopped; counter and o_divided_clk held at 0
//   ST_RUN   | counting and toggling o_divided_clk
//   ST_DRAIN | run dropped while output high; finish high phase, then idle
//
// Ports:
//   i_clk          system clock (only clock in the block)
//   i_rst          synchronous, active-high reset
//   i_run          1 = generate clock, 0 = stop (after drain)
//   cfg            slave side of the reconfiguration handshake
//   o_divided_clk  divided clock output, registered
//   o_tick         one-cycle pulse in the cycle after each toggle
//   o_running      1 in ST_RUN and ST_DRAIN
//   o_tick_count   16-bit wrapping count of tick cycles (TICK_COUNT_EN only)
//
// Optional feature macro: TICK_COUNT_EN adds the o_tick_count port/counter.
// -----------------------------------------------------------------------------
module clock_divider_controller #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_run,
    clock_divider_controller_if.slave  cfg,
    output logic                       o_divided_clk,
    output logic                       o_tick,
`ifdef TICK_COUNT_EN
    output logic [15:0]                o_tick_count,
`endif
    output logic                       o_running
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_counter;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_pend_div;
    logic             r_pending;
    logic             r_cfg_ready;
    logic             r_divided_clk;
    logic             r_tick;

    logic             w_wrap;
    logic             w_xfer;
    logic [WIDTH-1:0] w_counter_nxt;
    logic             w_divided_clk_nxt;
    logic             w_tick_nxt;
    logic             w_apply;

    // Config only changes at a wrap, so the counter never passes r_div and an
    // equality compare is enough to find the half-period boundary.
    assign w_wrap = (r_counter == r_div);
    assign w_xfer = cfg.cfg_valid & r_cfg_ready;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_run) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!i_run) begin
                    // Low output stops at once; high output must finish its
                    // phase. If that phase ends on this very edge there is
                    // nothing left to drain.
                    if (!r_divided_clk || w_wrap) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (i_run) begin
                    w_state_nxt = ST_RUN;
                end else if (w_wrap) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output / datapath next values
    always_comb begin
        w_counter_nxt     = r_counter;
        w_divided_clk_nxt = r_divided_clk;
        w_tick_nxt        = 1'b0;
        w_apply           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_counter_nxt     = '0;
                w_divided_clk_nxt = 1'b0;
                w_apply           = r_pending;
            end
            ST_RUN, ST_DRAIN: begin
                if ((r_state == ST_RUN) && !i_run && !r_divided_clk) begin
                    w_counter_nxt = '0;
                end else if (w_wrap) begin
                    w_counter_nxt     = '0;
                    w_divided_clk_nxt = ~r_divided_clk;
                    w_tick_nxt        = 1'b1;
                    w_apply           = r_pending;
                end else begin
                    w_counter_nxt = r_counter + 1'b1;
                end
            end
            default: begin
                w_counter_nxt     = '0;
                w_divided_clk_nxt = 1'b0;
            end
        endcase
    end

    // Datapath and handshake registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_counter     <= '0;
            r_div         <= WIDTH'(DEFAULT_DIV);
            r_pend_div    <= '0;
            r_pending     <= 1'b0;
            r_cfg_ready   <= 1'b1;
            r_divided_clk <= 1'b0;
            r_tick        <= 1'b0;
        end else begin
            r_counter     <= w_counter_nxt;
            r_divided_clk <= w_divided_clk_nxt;
            r_tick        <= w_tick_nxt;

            if (w_apply) begin
                r_div     <= r_pend_div;
                r_pending <= 1'b0;
            end

            // A transfer needs ready=1, which implies nothing is pending, so
            // it can never collide with an apply.
            if (w_xfer) begin
                r_pend_div  <= cfg.cfg_div;
                r_pending   <= 1'b1;
                r_cfg_ready <= 1'b0;
            end else if (!r_pending && !r_cfg_ready) begin
                // Reopen one edge after the apply.
                r_cfg_ready <= 1'b1;
            end
        end
    end

`ifdef TICK_COUNT_EN
    logic [15:0] r_tick_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tick_count <= '0;
        end else if (r_tick) begin
            r_tick_count <= r_tick_count + 16'd1;
        end
    end

    assign o_tick_count = r_tick_count;
`endif

    assign cfg.cfg_ready  = r_cfg_ready;
    assign o_divided_clk  = r_divided_clk;
    assign o_tick         = r_tick;
    assign o_running      = (r_state == ST_RUN) || (r_state == ST_DRAIN);

endmodule
